// File: rtl/div_seq_ctrl.sv
// EX-stage sequencer for the shared iterative 32-bit divider: latches operands, stalls the
// pipeline until the result returns, writes HI/LO, annuls on flush. Optional: DIV_ZERO_EXC_EN.
module div_seq_ctrl #(
  parameter int unsigned DIV_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stall_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        timeout_o,
  output logic        dbz_exc_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [5:0] TimeoutCnt = 6'(DIV_TIMEOUT);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        start_q, start_d;
  logic        annul_q, annul_d;
  logic        signed_q, signed_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        whilo_q, whilo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        timeout_q, timeout_d;
  logic        dbz_q, dbz_d;
  logic        stall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = start_q;
    annul_d   = 1'b0;
    signed_d  = signed_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    whilo_d   = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    timeout_d = 1'b0;
    dbz_d     = 1'b0;
    stall     = 1'b0;

    unique case (state_q)
      StIdle: begin
        start_d = 1'b0;
        if (div_req_i && !flush_i) begin
          stall = 1'b1;
`ifdef DIV_ZERO_EXC_EN
          if (op2_i == '0) begin
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
`else
          begin
`endif
            signed_d = div_signed_i;
            op1_d    = op1_i;
            op2_d    = op2_i;
            start_d  = 1'b1;
            cnt_d    = '0;
            state_d  = StBusy;
          end
        end
      end
      StBusy: begin
        start_d = 1'b1;
        cnt_d   = cnt_q + 6'd1;
        stall   = !div_ready_i;
        if (flush_i) begin
          annul_d = 1'b1;
          start_d = 1'b0;
          state_d = StIdle;
        end else if (div_ready_i) begin
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          whilo_d = 1'b1;
          start_d = 1'b0;
          state_d = StDone;
        end else if (cnt_q == TimeoutCnt) begin
          annul_d   = 1'b1;
          timeout_d = 1'b1;
          start_d   = 1'b0;
          state_d   = StIdle;
        end
      end
      StDone: begin
        start_d = 1'b0;
        state_d = StIdle;
        // A divide-by-zero already retired in its request cycle; only a new request stalls.
`ifdef DIV_ZERO_EXC_EN
        stall   = div_req_i && !dbz_q;
`else
        stall   = div_req_i;
`endif
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      annul_q   <= 1'b0;
      signed_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      whilo_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      timeout_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      annul_q   <= annul_d;
      signed_q  <= signed_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      whilo_q   <= whilo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      timeout_q <= timeout_d;
      dbz_q     <= dbz_d;
    end
  end

  assign div_start_o  = start_q;
  assign div_annul_o  = annul_q;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign stall_o      = stall;
  assign whilo_o      = whilo_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign timeout_o    = timeout_q;
  assign dbz_exc_o    = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: table of directed divides plus hand-written flush,
// timeout, reset and request-in-DONE sequences.
module tb_div_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        flush_i;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        stall_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        timeout_o;
  logic        dbz_exc_o;

  int total = 0;
  int bad   = 0;

  div_seq_ctrl #(.DIV_TIMEOUT(63)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req_i),
    .div_signed_i (div_signed_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .flush_i      (flush_i),
    .div_ready_i  (div_ready_i),
    .div_result_i (div_result_i),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_op1_o    (div_op1_o),
    .div_op2_o    (div_op2_o),
    .stall_o      (stall_o),
    .whilo_o      (whilo_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .timeout_o    (timeout_o),
    .dbz_exc_o    (dbz_exc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

`ifdef DIV_ZERO_EXC_EN
  localparam int NumVec = 3;
`else
  localparam int NumVec = 4;
`endif
  vec_t vecs[NumVec];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, 64'(div_start_o), 64'd0);
    chk({tag, "_annul"}, 64'(div_annul_o), 64'd0);
    chk({tag, "_signed"}, 64'(div_signed_o), 64'd0);
    chk({tag, "_op1"}, 64'(div_op1_o), 64'd0);
    chk({tag, "_op2"}, 64'(div_op2_o), 64'd0);
    chk({tag, "_whilo"}, 64'(whilo_o), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout_o), 64'd0);
    chk({tag, "_dbz"}, 64'(dbz_exc_o), 64'd0);
    chk({tag, "_hi"}, 64'(hi_o), 64'd0);
    chk({tag, "_lo"}, 64'(lo_o), 64'd0);
  endtask

  // Starts in an IDLE cycle, #1 after the edge; ends #1 after the edge entering IDLE again.
  task automatic do_div(input vec_t v);
    div_req_i    = 1'b1;
    div_signed_i = v.sgn;
    op1_i        = v.a;
    op2_i        = v.b;
    #1;
    chk("req_stall", 64'(stall_o), 64'd1);
    tick();
    chk("start_set", 64'(div_start_o), 64'd1);
    chk("annul_idle", 64'(div_annul_o), 64'd0);
    chk("signed_latch", 64'(div_signed_o), 64'(v.sgn));
    chk("op1_latch", 64'(div_op1_o), 64'(v.a));
    chk("op2_latch", 64'(div_op2_o), 64'(v.b));
    op1_i = ~v.a;
    op2_i = ~v.b;
    for (int i = 1; i < v.lat; i++) tick();
    chk("busy_stall", 64'(stall_o), 64'd1);
    chk("busy_start", 64'(div_start_o), 64'd1);
    div_ready_i  = 1'b1;
    div_result_i = v.res;
    #1;
    chk("ready_stall", 64'(stall_o), 64'd0);
    chk("op1_held", 64'(div_op1_o), 64'(v.a));
    tick();
    div_ready_i  = 1'b0;
    div_result_i = '0;
    div_req_i    = 1'b0;
    #1;
    chk("whilo_pulse", 64'(whilo_o), 64'd1);
    chk("hi", 64'(hi_o), 64'(v.hi));
    chk("lo", 64'(lo_o), 64'(v.lo));
    chk("done_start", 64'(div_start_o), 64'd0);
    chk("done_stall", 64'(stall_o), 64'd0);
    tick();
    chk("whilo_once", 64'(whilo_o), 64'd0);
    chk("idle_start", 64'(div_start_o), 64'd0);
  endtask

  initial begin
    vec_t v;
    int   n;

    vecs[0] = '{sgn: 1'b0, a: 32'd100, b: 32'd7, res: {32'd2, 32'd14},
                hi: 32'd2, lo: 32'd14, lat: 34};
    vecs[1] = '{sgn: 1'b1, a: 32'hFFFF_FFF9, b: 32'd2, res: {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, lat: 34};
    vecs[2] = '{sgn: 1'b0, a: 32'h1234_5678, b: 32'h10, res: {32'h8, 32'h0123_4567},
                hi: 32'h8, lo: 32'h0123_4567, lat: 5};
`ifndef DIV_ZERO_EXC_EN
    vecs[3] = '{sgn: 1'b0, a: 32'd5, b: 32'd0, res: 64'd0, hi: 32'd0, lo: 32'd0, lat: 34};
`endif

    rst = 1'b1;
    div_req_i = 1'b0;
    div_signed_i = 1'b0;
    op1_i = '0;
    op2_i = '0;
    flush_i = 1'b0;
    div_ready_i = 1'b0;
    div_result_i = '0;
    tick();
    tick();
    chk_reset_vals("rst0");
    chk("rst0_stall", 64'(stall_o), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NumVec; i++) do_div(vecs[i]);

    // Flush 10 cycles into BUSY, then a new divide right away.
    div_req_i = 1'b1; div_signed_i = 1'b0; op1_i = 32'd100; op2_i = 32'd7;
    tick();
    div_req_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush_i = 1'b1;
    #1;
    chk("flush_stall", 64'(stall_o), 64'd0);
    tick();
    flush_i = 1'b0;
    chk("flush_annul", 64'(div_annul_o), 64'd1);
    chk("flush_start", 64'(div_start_o), 64'd0);
    chk("flush_whilo", 64'(whilo_o), 64'd0);
    v = '{sgn: 1'b0, a: 32'd9, b: 32'd3, res: {32'd0, 32'd3}, hi: 32'd0, lo: 32'd3, lat: 34};
    do_div(v);

    // Timeout: ready never comes.
    div_req_i = 1'b1; div_signed_i = 1'b0; op1_i = 32'd50; op2_i = 32'd5;
    tick();
    div_req_i = 1'b0;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (timeout_o || whilo_o) begin
        n = i;
        break;
      end
    end
    chk("timeout_cycles", 64'(n), 64'd64);
    chk("timeout_annul", 64'(div_annul_o), 64'd1);
    chk("timeout_whilo", 64'(whilo_o), 64'd0);
    chk("timeout_start", 64'(div_start_o), 64'd0);
    tick();
    chk("timeout_once", 64'(timeout_o), 64'd0);
    chk("timeout_annul_once", 64'(div_annul_o), 64'd0);
    chk("timeout_lo_kept", 64'(lo_o), 64'd3);

`ifdef DIV_ZERO_EXC_EN
    div_req_i = 1'b1; div_signed_i = 1'b0; op1_i = 32'd5; op2_i = 32'd0;
    #1;
    chk("dbz_stall_t", 64'(stall_o), 64'd1);
    tick();
    chk("dbz_pulse", 64'(dbz_exc_o), 64'd1);
    chk("dbz_start", 64'(div_start_o), 64'd0);
    chk("dbz_whilo", 64'(whilo_o), 64'd0);
    chk("dbz_stall_t1", 64'(stall_o), 64'd0);
    div_req_i = 1'b0;
    tick();
    chk("dbz_once", 64'(dbz_exc_o), 64'd0);
    chk("dbz_start_idle", 64'(div_start_o), 64'd0);
`endif

    // Request arriving in DONE is held one cycle, then accepted from IDLE.
    div_req_i = 1'b1; div_signed_i = 1'b0; op1_i = 32'd20; op2_i = 32'd6;
    tick();
    div_req_i = 1'b0;
    tick();
    div_ready_i = 1'b1; div_result_i = {32'd2, 32'd3};
    tick();
    div_ready_i = 1'b0;
    div_req_i = 1'b1; div_signed_i = 1'b1; op1_i = 32'hDEAD_0001; op2_i = 32'h0000_0101;
    #1;
    chk("done_req_stall", 64'(stall_o), 64'd1);
    chk("done_req_whilo", 64'(whilo_o), 64'd1);
    tick();
    chk("done_req_nostart", 64'(div_start_o), 64'd0);
    chk("done_req_idle_stall", 64'(stall_o), 64'd1);
    tick();
    chk("done_req_start", 64'(div_start_o), 64'd1);
    chk("done_req_op1", 64'(div_op1_o), 64'hDEAD_0001);
    chk("done_req_signed", 64'(div_signed_o), 64'd1);

    // Reset mid-BUSY clears every output.
    div_req_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("rst_busy");
    rst = 1'b0;
    div_req_i = 1'b1; div_signed_i = 1'b0; op1_i = 32'd8; op2_i = 32'd2;
    #1;
    chk("post_rst_stall", 64'(stall_o), 64'd1);
    tick();
    chk("post_rst_start", 64'(div_start_o), 64'd1);
    div_req_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("post_rst_annul", 64'(div_annul_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
